// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants and types: FSM states and round-key storage shapes.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  typedef logic [KEY_W-1:0] round_key_t;
  typedef round_key_t rk_store_t [0:NUM_ROUNDS];

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-load handshake and round-key read port between the key source/round datapath and the schedule.
interface aes_key_schedule_if #(
  parameter int KEY_W = 128
);
  // key_in transfers on a rising edge where key_valid && key_ready; the source keeps key_valid
  // and key_in stable until that edge, and key_ready never depends combinationally on key_valid.
  logic             key_valid;
  logic [KEY_W-1:0] key_in;
  logic             key_ready;
  logic             busy;
  logic             keys_valid;
  logic [3:0]       rd_addr;
  logic [KEY_W-1:0] rd_data;
  aes_pkg::ks_state_t state;

  modport master (
    output key_valid, key_in, rd_addr,
    input  key_ready, busy, keys_valid, rd_data, state
  );

  modport slave (
    input  key_valid, key_in, rd_addr,
    output key_ready, busy, keys_valid, rd_data, state
  );

endinterface

// File: rtl/key_expansion.sv
// One AES-128 key-expansion round (round key r -> r+1), purely combinational.
module key_expansion
  import aes_pkg::*;
(
  input  logic [3:0] num_round,
  input  round_key_t input_key,
  output round_key_t output_key
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box as x^254 (GF(2^8) inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    rcon = 8'h00;
    case (num_round)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0 = input_key[127:96];
  assign w1 = input_key[95:64];
  assign w2 = input_key[63:32];
  assign w3 = input_key[31:0];

  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
                {rcon, 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign output_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: one expansion round per clock into an (NUM_ROUNDS+1)-entry
// round-key store, served through a registered read port.
module aes_key_schedule #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_key_schedule_if.slave  bus
);
  import aes_pkg::ks_state_t;
  import aes_pkg::round_key_t;
  import aes_pkg::IDLE;
  import aes_pkg::EXPAND;
  import aes_pkg::DONE;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] TOP_IDX  = 4'(NUM_ROUNDS);

  ks_state_t        state_q;
  logic [3:0]       round_cnt_q;
  logic [KEY_W-1:0] cur_key_q;
  logic             key_ready_q;
  logic             busy_q;
  logic             keys_valid_q;
  logic [KEY_W-1:0] rd_data_q;
  logic [KEY_W-1:0] rd_data_d;
  logic [KEY_W-1:0] slot_q [0:NUM_ROUNDS];

  round_key_t       exp_key;
  logic             accept;
  logic [3:0]       wr_idx;

  assign accept = bus.key_valid && key_ready_q;
  assign wr_idx = round_cnt_q + 4'd1;

  key_expansion u_key_expansion (
    .num_round  (round_cnt_q),
    .input_key  (cur_key_q),
    .output_key (exp_key)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      round_cnt_q  <= 4'd0;
      cur_key_q    <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q      <= EXPAND;
            round_cnt_q  <= 4'd0;
            cur_key_q    <= bus.key_in;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
          end
        end
        EXPAND: begin
          cur_key_q   <= exp_key;
          round_cnt_q <= wr_idx;
          if (round_cnt_q == LAST_RND) begin
            state_q      <= DONE;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          key_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Key storage is deliberately not reset; keys_valid is what qualifies its contents.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (accept) begin
        slot_q[0] <= bus.key_in;
      end else if (state_q == EXPAND) begin
        slot_q[wr_idx] <= exp_key;
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (bus.rd_addr <= TOP_IDX) rd_data_d = slot_q[bus.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign bus.key_ready  = key_ready_q;
  assign bus.busy       = busy_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: random and FIPS-197 keys, handshake/reset timing and a read scoreboard.
module tb_aes_key_schedule;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_key_schedule_if bus_if ();

  aes_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [127:0] exp_q [$];
  logic [7:0]   sbox_t [256];
  logic [127:0] model_rk [11];
  logic         rd_issue = 1'b0;
  logic         rd_pend  = 1'b0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from the generator-3 walk of GF(2^8): p steps by *3, q tracks its inverse.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Full 44-word schedule, sliced into 11 round keys.
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(posedge clk) rd_pend <= rd_issue;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL rd_unexpected: got %h with no expected entry", bus_if.rd_data);
      end else begin
        check("rd_data", bus_if.rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic read(input int addr, input logic [127:0] exp);
    bus_if.rd_addr = 4'(addr);
    rd_issue = 1'b1;
    exp_q.push_back(exp);
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic read_model(input int addr);
    read(addr, (addr <= 10) ? model_rk[addr] : 128'h0);
  endtask

  // Returns in cycle 1 (the cycle after the accept edge).
  task automatic load_key(input logic [127:0] key);
    int waited;
    waited = 0;
    bus_if.key_in    = key;
    bus_if.key_valid = 1'b1;
    while (!bus_if.key_ready && waited < 30) begin
      tick();
      waited++;
    end
    if (!bus_if.key_ready) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL load_timeout: key_ready=0 required 1");
    end
    tick();
    bus_if.key_valid = 1'b0;
    model_expand(key);
  endtask

  // Flags are {key_ready, busy, keys_valid}; from cycle 1 to cycle 11.
  task automatic expand_checks();
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("expand_flags_c%0d", k),
            {bus_if.key_ready, bus_if.busy, bus_if.keys_valid}, 3'b010);
      tick();
    end
    check("done_flags_c11", {bus_if.key_ready, bus_if.busy, bus_if.keys_valid}, 3'b101);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key_a;
    logic [127:0] key_b;
    build_sbox();
    rst_n            = 1'b0;
    bus_if.key_valid = 1'b0;
    bus_if.key_in    = '0;
    bus_if.rd_addr   = 4'd0;
    repeat (3) tick();
    check("reset_flags", {bus_if.key_ready, bus_if.busy, bus_if.keys_valid}, 3'b100);
    check("reset_rd_data", bus_if.rd_data, 128'h0);
    check("reset_state", 128'(bus_if.state), 128'(aes_pkg::IDLE));
    rst_n = 1'b1;
    tick();

    // FIPS-197 key
    load_key(FIPS_KEY);
    expand_checks();
    read(1, FIPS_RK1);
    read(10, FIPS_RK10);
    read(0, FIPS_KEY);
    for (int a = 0; a < 16; a++) read_model(a);

    // Second key held valid throughout EXPAND
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = {$urandom, $urandom, $urandom, $urandom};
    load_key(key_a);
    bus_if.key_in    = key_b;
    bus_if.key_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("hold_ready_c%0d", k), {bus_if.key_ready, bus_if.keys_valid}, 2'b00);
      tick();
    end
    check("hold_c11", {bus_if.key_ready, bus_if.keys_valid}, 2'b11);
    tick();
    bus_if.key_valid = 1'b0;
    model_expand(key_b);
    expand_checks();
    for (int a = 0; a < 11; a++) read_model(a);

    // Reset at cycle 5 of EXPAND
    bus_if.rd_addr = 4'd1;
    load_key({$urandom, $urandom, $urandom, $urandom});
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_flags", {bus_if.key_ready, bus_if.busy, bus_if.keys_valid}, 3'b100);
    check("midrst_rd_data", bus_if.rd_data, 128'h0);
    check("midrst_state", 128'(bus_if.state), 128'(aes_pkg::IDLE));
    rst_n = 1'b1;
    tick();
    load_key({$urandom, $urandom, $urandom, $urandom});
    expand_checks();
    for (int a = 0; a < 11; a++) read_model(a);

    // Reload all-zero key in DONE after the FIPS key
    load_key(FIPS_KEY);
    expand_checks();
    load_key(128'h0);
    expand_checks();
    read(10, ZERO_RK10);
    for (int a = 11; a < 16; a++) read(a, 128'h0);
    read(0, 128'h0);
    read_model(5);

    // Random keys with random reads
    repeat (6) begin
      load_key({$urandom, $urandom, $urandom, $urandom});
      expand_checks();
      repeat (6) read_model($urandom_range(0, 15));
    end

    tick();
    tick();
    check("exp_q_drained", 128'(exp_q.size()), 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
